sram_controller: RTL and testbench

- Back end of the data-memory path. Consumes the single-word read/write requests issued by the cache controller and drives a 16-bit-wide asynchronous external SRAM (256K x 16).
- Returns a full 64-bit, 8-byte-aligned line for reads, which is the cache refill width.
- Writes one 32-bit word as two halfword cycles.
- Pulses `ready` once per completed request.

---
 rtl/sram_controller.sv | 156 +++++++++++++++
 tb/tb_sram_controller.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_controller.sv
// Purpose: cache-side request to 16-bit async SRAM; 64-bit line reads, 32-bit two-halfword writes.
// Latency: read 4*(WAIT_CYCLES+1)+1, write 2*(WAIT_CYCLES+1)+1 cycles from accept to ready.
// Backpressure: requester holds its enable level until the one-cycle ready pulse; no queueing.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   address, wdata           CPU byte address / store word, held stable while pending
//   read_en, write_en        request levels, held until ready (write wins if both set)
//   rdata, ready             8-byte-aligned line (updated only on read completion), done pulse
//   sram_*                   external SRAM bus (18-bit halfword address, 16-bit dq)
// Optional macro: SRAM_READ_BUFFER_EN adds a one-entry line buffer that short-circuits
// repeated reads of the same line straight to DONE.
module sram_controller #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned BASE_ADDR   = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    input  logic        read_en,
    input  logic        write_en,
    output logic [63:0] rdata,
    output logic        ready,
    inout  wire  [15:0] sram_dq,
    output logic [17:0] sram_addr,
    output logic        sram_we_n,
    output logic        sram_oe_n,
    output logic        sram_ce_n,
    output logic        sram_ub_n,
    output logic        sram_lb_n
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    localparam logic [3:0] LAST_CYC = 4'(WAIT_CYCLES);

    state_t      state, next_state;
    logic [3:0]  cyc_cnt;
    logic [1:0]  slot;
    logic [47:0] line;      // lower three halfwords of the line being assembled
    logic [31:0] adr;
    logic        slot_end;
    logic        dq_oe;
    logic [15:0] dq_out;
    logic        buf_hit;
    logic        read_last;

    assign adr       = address - BASE_ADDR;
    assign slot_end  = (cyc_cnt == LAST_CYC);
    assign read_last = (state == READ) && slot_end && (slot == 2'd3);

    // Address bits outside the 512 KB window and the byte-select bit are intentionally dropped.
    wire unused_adr_bits = ^{adr[31:19], adr[0]};

`ifdef SRAM_READ_BUFFER_EN
    logic        buf_vld;
    logic [15:0] buf_tag;

    assign buf_hit = buf_vld && (buf_tag == adr[18:3]);

    // rdata always holds the most recent line read, so a hit needs no data path of its own.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_vld <= 1'b0;
            buf_tag <= '0;
        end else if (state == IDLE && write_en && adr[18:3] == buf_tag) begin
            buf_vld <= 1'b0;
        end else if (read_last) begin
            buf_vld <= 1'b1;
            buf_tag <= adr[18:3];
        end
    end
`else
    assign buf_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (write_en)     next_state = WRITE;
                else if (read_en) next_state = buf_hit ? DONE : READ;
            end
            READ:    if (slot_end && slot == 2'd3) next_state = DONE;
            WRITE:   if (slot_end && slot == 2'd1) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // SRAM pins are decoded straight from state so an asynchronous reset releases the bus at once.
    always_comb begin
        sram_addr = '0;
        sram_ce_n = 1'b1;
        sram_oe_n = 1'b1;
        sram_we_n = 1'b1;
        dq_oe     = 1'b0;
        dq_out    = '0;
        case (state)
            READ: begin
                sram_addr = {adr[18:3], slot};
                sram_ce_n = 1'b0;
                sram_oe_n = 1'b0;
            end
            WRITE: begin
                sram_addr = {adr[18:2], slot[0]};
                sram_ce_n = 1'b0;
                // we_n rises in the slot's last cycle while address and data are still held.
                sram_we_n = slot_end;
                dq_oe     = 1'b1;
                dq_out    = slot[0] ? wdata[31:16] : wdata[15:0];
            end
            default: ;
        endcase
    end

    assign sram_dq   = dq_oe ? dq_out : 16'bz;
    assign sram_ub_n = sram_ce_n;
    assign sram_lb_n = sram_ce_n;
    assign ready     = (state == DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc_cnt <= '0;
            slot    <= '0;
            line    <= '0;
            rdata   <= '0;
        end else if (state == READ || state == WRITE) begin
            if (slot_end) begin
                cyc_cnt <= '0;
                slot    <= slot + 2'd1;
            end else begin
                cyc_cnt <= cyc_cnt + 4'd1;
            end
            if (state == READ && slot_end) begin
                case (slot)
                    2'd0: line[15:0]  <= sram_dq;
                    2'd1: line[31:16] <= sram_dq;
                    2'd2: line[47:32] <= sram_dq;
                    // Final halfword goes straight into rdata so it is complete in DONE.
                    default: rdata <= {sram_dq, line};
                endcase
            end
        end else begin
            cyc_cnt <= '0;
            slot    <= '0;
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
module tb_sram_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] address;
    logic [31:0] wdata;
    logic        read_en;
    logic        write_en;
    logic [63:0] rdata;
    logic        ready;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;

    always #5 clk = ~clk;

    sram_controller dut (
        .clk       (clk),
        .rst       (rst),
        .address   (address),
        .wdata     (wdata),
        .read_en   (read_en),
        .write_en  (write_en),
        .rdata     (rdata),
        .ready     (ready),
        .sram_dq   (sram_dq),
        .sram_addr (sram_addr),
        .sram_we_n (sram_we_n),
        .sram_oe_n (sram_oe_n),
        .sram_ce_n (sram_ce_n),
        .sram_ub_n (sram_ub_n),
        .sram_lb_n (sram_lb_n)
    );

`ifdef SRAM_READ_BUFFER_EN
    localparam int HIT_LAT = 1;
    localparam int HIT_CE  = 0;
`else
    localparam int HIT_LAT = 9;
    localparam int HIT_CE  = 8;
`endif

    // ---------------- SRAM model ----------------
    logic [15:0] mem [0:63];
    logic        pl_en;
    logic [5:0]  pl_idx;
    logic [15:0] pl_dat;
    logic        probe_en;
    wire         unused_hi = ^sram_addr[17:6];

    assign sram_dq = (!sram_ce_n && !sram_oe_n && sram_we_n) ? mem[sram_addr[5:0]] : 16'bz;
    assign sram_dq = probe_en ? 16'h5A5A : 16'bz;

    always @(posedge clk) begin
        if (pl_en) mem[pl_idx] <= pl_dat;
        else if (!sram_ce_n && !sram_we_n) mem[sram_addr[5:0]] <= sram_dq;
    end

    // ---------------- bookkeeping ----------------
    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int acc_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          lat;
        logic [63:0] rd;
        bit          chk_rd;
    } exp_t;
    exp_t sb[$];

    logic [17:0] addr_log[$];
    int we_low, oe_low, ce_low, be_bad;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: every ready pulse is matched against the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst === 1'b1 && ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_ready", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("latency", 64'(cyc - acc_cyc + 1), 64'(e.lat));
                if (e.chk_rd) chk("rdata", rdata, e.rd);
            end
        end
    end

    task automatic preload(input logic [5:0] idx, input logic [15:0] v);
        @(negedge clk);
        pl_en  = 1'b1;
        pl_idx = idx;
        pl_dat = v;
        @(negedge clk);
        pl_en  = 1'b0;
    endtask

    task automatic do_req(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d,
                          input int lat, input logic [63:0] exp_rd, input bit chk_rd);
        exp_t e;
        bit   seen;
        @(negedge clk);
        address  = a;
        wdata    = d;
        write_en = wr;
        read_en  = rd;
        e.lat    = lat;
        e.rd     = exp_rd;
        e.chk_rd = chk_rd;
        sb.push_back(e);
        acc_cyc  = cyc + 1;
        addr_log.delete();
        we_low = 0; oe_low = 0; ce_low = 0; be_bad = 0;
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            if (!sram_we_n) we_low++;
            if (!sram_oe_n) oe_low++;
            if (!sram_ce_n) ce_low++;
            if (!sram_ce_n && (sram_ub_n || sram_lb_n)) be_bad++;
            if (ready) seen = 1'b1;
            else       addr_log.push_back(sram_addr);
        end
        if (!seen) chk("req_timeout", 64'd0, 64'd1);
        write_en = 1'b0;
        read_en  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen_abort;
        rst = 1'b0; address = '0; wdata = 32'hFFFF_FFFF;
        read_en = 1'b0; write_en = 1'b0;
        pl_en = 1'b0; pl_idx = '0; pl_dat = '0; probe_en = 1'b0;

        // Preload while the controller is held in reset.
        for (int i = 0; i < 16; i++) preload(6'(i), 16'h0000);
        preload(6'd4, 16'h1111);
        preload(6'd5, 16'h2222);
        preload(6'd6, 16'h3333);
        preload(6'd7, 16'h4444);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("reset_ready",  64'(ready),     64'd0);
        chk("reset_rdata",  rdata,          64'd0);
        chk("reset_ce_n",   64'(sram_ce_n), 64'd1);
        chk("reset_we_n",   64'(sram_we_n), 64'd1);
        chk("reset_oe_n",   64'(sram_oe_n), 64'd1);
        chk("reset_addr",   64'(sram_addr), 64'd0);
        probe_en = 1'b1;
        #1;
        chk("reset_dq_released", 64'(sram_dq), 64'h5A5A);
        probe_en = 1'b0;

        // Write then read back.
        do_req(1'b1, 1'b0, 32'd1024, 32'hDEAD_BEEF, 5, 64'd0, 1'b0);
        chk("wr_we_low_cycles", 64'(we_low), 64'd2);
        chk("wr_oe_low_cycles", 64'(oe_low), 64'd0);
        chk("wr_byte_enables",  64'(be_bad), 64'd0);
        chk("wr_mem0", 64'(mem[0]), 64'hBEEF);
        chk("wr_mem1", 64'(mem[1]), 64'hDEAD);
        do_req(1'b0, 1'b1, 32'd1028, 32'd0, 9, 64'h0000_0000_DEAD_BEEF, 1'b1);

        // Line assembly and address stepping.
        do_req(1'b0, 1'b1, 32'd1036, 32'd0, 9, 64'h4444_3333_2222_1111, 1'b1);
        chk("rd_be_enables", 64'(be_bad), 64'd0);
        chk("rd_addr_log_len", 64'(addr_log.size()), 64'd8);
        for (int i = 0; i < addr_log.size() && i < 8; i++)
            chk($sformatf("rd_addr_step%0d", i), 64'(addr_log[i]), 64'(4 + i / 2));

        // Both enables high: write wins.
        do_req(1'b1, 1'b1, 32'd1032, 32'd5, 5, 64'd0, 1'b0);
        chk("prio_oe_low_cycles", 64'(oe_low), 64'd0);
        chk("prio_mem4", 64'(mem[4]), 64'h0005);
        chk("prio_mem5", 64'(mem[5]), 64'h0000);

        // Reset during slot 2 of a read: no expectation is queued, so any ready is spurious.
        @(negedge clk);
        address = 32'd1036;
        read_en = 1'b1;
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("abort_ce_n",  64'(sram_ce_n), 64'd1);
        chk("abort_oe_n",  64'(sram_oe_n), 64'd1);
        chk("abort_addr",  64'(sram_addr), 64'd0);
        chk("abort_ready", 64'(ready),     64'd0);
        chk("abort_rdata", rdata,          64'd0);
        @(negedge clk);
        read_en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        seen_abort = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (ready) seen_abort = 1'b1;
        end
        chk("abort_no_ready", 64'(seen_abort), 64'd0);
        do_req(1'b0, 1'b1, 32'd1036, 32'd0, 9, 64'h4444_3333_0000_0005, 1'b1);

        // Repeated read of one line, then a write into that line invalidates it.
        do_req(1'b0, 1'b1, 32'd1024, 32'd0, 9, 64'h0000_0000_DEAD_BEEF, 1'b1);
        do_req(1'b0, 1'b1, 32'd1024, 32'd0, HIT_LAT, 64'h0000_0000_DEAD_BEEF, 1'b1);
        chk("reread_ce_low_cycles", 64'(ce_low), 64'(HIT_CE));
        do_req(1'b1, 1'b0, 32'd1028, 32'hCAFE_F00D, 5, 64'd0, 1'b0);
        do_req(1'b0, 1'b1, 32'd1024, 32'd0, 9, 64'hCAFE_F00D_DEAD_BEEF, 1'b1);
        chk("post_write_ce_low_cycles", 64'(ce_low), 64'd8);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
